control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: three-step fetch (T0-T2), opcode-dependent execute (T3-T7),
// plus RST and HALT. All strobes decode combinationally from the registered step and are gated by stall.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  opcode,
    input  logic        con_ff,
    input  logic        stall,
    output logic [8:0]  busout,
    output logic [10:0] busin,
    output logic [2:0]  gr,
    output logic        ba_out,
    output logic        inc_pc,
    output logic [2:0]  mdr_sel,
    output logic        ram_write,
    output logic [4:0]  alu_op,
    output logic        run
);

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_NOP    = 4'd0,
        C_RTYPE  = 4'd1,
        C_IMM    = 4'd2,
        C_LD     = 4'd3,
        C_LDI    = 4'd4,
        C_ST     = 4'd5,
        C_MULDIV = 4'd6,
        C_BR     = 4'd7,
        C_OUT    = 4'd8,
        C_IN     = 4'd9,
        C_HALT   = 4'd10
    } iclass_t;

    localparam logic [8:0]  BO_R    = 9'h100;
    localparam logic [8:0]  BO_ZH   = 9'h020;
    localparam logic [8:0]  BO_ZL   = 9'h010;
    localparam logic [8:0]  BO_PC   = 9'h008;
    localparam logic [8:0]  BO_MDR  = 9'h004;
    localparam logic [8:0]  BO_INP  = 9'h002;
    localparam logic [8:0]  BO_C    = 9'h001;

    localparam logic [10:0] BI_R    = 11'h400;
    localparam logic [10:0] BI_HI   = 11'h200;
    localparam logic [10:0] BI_LO   = 11'h100;
    localparam logic [10:0] BI_Z    = 11'h080;
    localparam logic [10:0] BI_Y    = 11'h040;
    localparam logic [10:0] BI_PC   = 11'h020;
    localparam logic [10:0] BI_IR   = 11'h010;
    localparam logic [10:0] BI_MAR  = 11'h008;
    localparam logic [10:0] BI_MDR  = 11'h004;
    localparam logic [10:0] BI_CON  = 11'h002;
    localparam logic [10:0] BI_OUTP = 11'h001;

    localparam logic [2:0]  GR_A    = 3'b100;
    localparam logic [2:0]  GR_B    = 3'b010;
    localparam logic [2:0]  GR_C    = 3'b001;

    localparam logic [2:0]  MDR_BUS = 3'b001;
    localparam logic [2:0]  MDR_RAM = 3'b010;
    localparam logic [4:0]  ALU_ADD = 5'b00011;

    state_t      state_r;
    iclass_t     iclass_s;
    logic [8:0]  dec_busout_s;
    logic [10:0] dec_busin_s;
    logic [2:0]  dec_gr_s;
    logic        dec_ba_out_s;
    logic        dec_inc_pc_s;
    logic [2:0]  dec_mdr_sel_s;
    logic        dec_ram_write_s;
    logic [4:0]  dec_alu_op_s;

    // Classify the opcode into the execute sequence it selects.
    always_comb begin
        iclass_s = C_NOP;
        case (opcode)
            5'd0:                                   iclass_s = C_LD;
            5'd1:                                   iclass_s = C_LDI;
            5'd2:                                   iclass_s = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd9, 5'd10, 5'd11:                     iclass_s = C_RTYPE;
            5'd12, 5'd13, 5'd14:                    iclass_s = C_IMM;
            5'd15, 5'd16:                           iclass_s = C_MULDIV;
            5'd19:                                  iclass_s = C_BR;
            5'd22:                                  iclass_s = C_IN;
            5'd23:                                  iclass_s = C_OUT;
            5'd27:                                  iclass_s = C_HALT;
            default:                                iclass_s = C_NOP;
        endcase
    end

    // Step sequencer; clr wins asynchronously, stall freezes the current step.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_RST;
        end else if (stall) begin
            state_r <= state_r;
        end else begin
            case (state_r)
                ST_RST:  state_r <= ST_T0;
                ST_T0:   state_r <= ST_T1;
                ST_T1:   state_r <= ST_T2;
                ST_T2:   state_r <= (iclass_s == C_NOP) ? ST_T0 : ST_T3;
                ST_T3: begin
                    case (iclass_s)
                        C_HALT:                 state_r <= ST_HALT;
                        C_OUT, C_IN, C_NOP:     state_r <= ST_T0;
                        default:                state_r <= ST_T4;
                    endcase
                end
                ST_T4: begin
                    case (iclass_s)
                        C_RTYPE, C_IMM, C_LD, C_LDI,
                        C_ST, C_MULDIV, C_BR:   state_r <= ST_T5;
                        default:                state_r <= ST_T0;
                    endcase
                end
                ST_T5: begin
                    case (iclass_s)
                        C_LD, C_ST, C_MULDIV, C_BR: state_r <= ST_T6;
                        default:                    state_r <= ST_T0;
                    endcase
                end
                ST_T6: begin
                    case (iclass_s)
                        C_LD, C_ST:             state_r <= ST_T7;
                        default:                state_r <= ST_T0;
                    endcase
                end
                ST_T7:   state_r <= ST_T0;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RST;
            endcase
        end
    end

    // Per-step strobe decode before stall gating.
    always_comb begin
        dec_busout_s    = 9'd0;
        dec_busin_s     = 11'd0;
        dec_gr_s        = 3'd0;
        dec_ba_out_s    = 1'b0;
        dec_inc_pc_s    = 1'b0;
        dec_mdr_sel_s   = 3'd0;
        dec_ram_write_s = 1'b0;
        dec_alu_op_s    = ALU_ADD;
        case (state_r)
            ST_T0: begin
                dec_busout_s = BO_PC;
                dec_busin_s  = BI_MAR | BI_Z;
                dec_inc_pc_s = 1'b1;
            end
            ST_T1: begin
                dec_busout_s  = BO_ZL;
                dec_busin_s   = BI_PC | BI_MDR;
                dec_mdr_sel_s = MDR_RAM;
            end
            ST_T2: begin
                dec_busout_s = BO_MDR;
                dec_busin_s  = BI_IR;
            end
            ST_T3: begin
                case (iclass_s)
                    C_RTYPE, C_IMM: begin
                        dec_gr_s = GR_B; dec_busout_s = BO_R; dec_busin_s = BI_Y;
                    end
                    C_LD, C_LDI, C_ST: begin
                        dec_gr_s = GR_B; dec_busout_s = BO_R; dec_busin_s = BI_Y;
                        dec_ba_out_s = 1'b1;
                    end
                    C_MULDIV: begin
                        dec_gr_s = GR_A; dec_busout_s = BO_R; dec_busin_s = BI_Y;
                    end
                    C_BR: begin
                        dec_gr_s = GR_A; dec_busout_s = BO_R; dec_busin_s = BI_CON;
                    end
                    C_OUT: begin
                        dec_gr_s = GR_A; dec_busout_s = BO_R; dec_busin_s = BI_OUTP;
                    end
                    C_IN: begin
                        dec_gr_s = GR_A; dec_busout_s = BO_INP; dec_busin_s = BI_R;
                    end
                    default: dec_busout_s = 9'd0;
                endcase
            end
            ST_T4: begin
                case (iclass_s)
                    C_RTYPE: begin
                        dec_gr_s = GR_C; dec_busout_s = BO_R; dec_busin_s = BI_Z;
                        dec_alu_op_s = opcode;
                    end
                    C_IMM: begin
                        dec_busout_s = BO_C; dec_busin_s = BI_Z; dec_alu_op_s = opcode;
                    end
                    C_LD, C_LDI, C_ST: begin
                        dec_busout_s = BO_C; dec_busin_s = BI_Z;
                    end
                    C_MULDIV: begin
                        dec_gr_s = GR_B; dec_busout_s = BO_R; dec_busin_s = BI_Z;
                        dec_alu_op_s = opcode;
                    end
                    C_BR: begin
                        dec_busout_s = BO_PC; dec_busin_s = BI_Y;
                    end
                    default: dec_busout_s = 9'd0;
                endcase
            end
            ST_T5: begin
                case (iclass_s)
                    C_RTYPE, C_IMM, C_LDI: begin
                        dec_busout_s = BO_ZL; dec_gr_s = GR_A; dec_busin_s = BI_R;
                    end
                    C_LD, C_ST: begin
                        dec_busout_s = BO_ZL; dec_busin_s = BI_MAR;
                    end
                    C_MULDIV: begin
                        dec_busout_s = BO_ZL; dec_busin_s = BI_LO;
                    end
                    C_BR: begin
                        dec_busout_s = BO_C; dec_busin_s = BI_Z;
                    end
                    default: dec_busout_s = 9'd0;
                endcase
            end
            ST_T6: begin
                case (iclass_s)
                    C_LD: begin
                        dec_mdr_sel_s = MDR_RAM; dec_busin_s = BI_MDR;
                    end
                    C_ST: begin
                        dec_gr_s = GR_A; dec_busout_s = BO_R;
                        dec_mdr_sel_s = MDR_BUS; dec_busin_s = BI_MDR;
                    end
                    C_MULDIV: begin
                        dec_busout_s = BO_ZH; dec_busin_s = BI_HI;
                    end
                    C_BR: begin
                        // Branch taken only when the condition flip-flop is set.
                        if (con_ff) begin
                            dec_busout_s = BO_ZL; dec_busin_s = BI_PC;
                        end else begin
                            dec_busout_s = 9'd0; dec_busin_s = 11'd0;
                        end
                    end
                    default: dec_busout_s = 9'd0;
                endcase
            end
            ST_T7: begin
                case (iclass_s)
                    C_LD: begin
                        dec_busout_s = BO_MDR; dec_gr_s = GR_A; dec_busin_s = BI_R;
                    end
                    C_ST:    dec_ram_write_s = 1'b1;
                    default: dec_busout_s = 9'd0;
                endcase
            end
            default: dec_busout_s = 9'd0;
        endcase
    end

    assign busout    = stall ? 9'd0  : dec_busout_s;
    assign busin     = stall ? 11'd0 : dec_busin_s;
    assign gr        = stall ? 3'd0  : dec_gr_s;
    assign ba_out    = stall ? 1'b0  : dec_ba_out_s;
    assign inc_pc    = stall ? 1'b0  : dec_inc_pc_s;
    assign mdr_sel   = stall ? 3'd0  : dec_mdr_sel_s;
    assign ram_write = stall ? 1'b0  : dec_ram_write_s;
    assign alu_op    = stall ? ALU_ADD : dec_alu_op_s;
    assign run       = (state_r != ST_RST) && (state_r != ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues hand-derived expected output vectors,
// a monitor pops and compares them each sampling point.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic        con_ff = 1'b0;
    logic        stall = 1'b0;
    logic [8:0]  busout;
    logic [10:0] busin;
    logic [2:0]  gr;
    logic        ba_out;
    logic        inc_pc;
    logic [2:0]  mdr_sel;
    logic        ram_write;
    logic [4:0]  alu_op;
    logic        run;

    control_unit dut (
        .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff), .stall(stall),
        .busout(busout), .busin(busin), .gr(gr), .ba_out(ba_out), .inc_pc(inc_pc),
        .mdr_sel(mdr_sel), .ram_write(ram_write), .alu_op(alu_op), .run(run)
    );

    always #5 clk = ~clk;

    localparam logic [8:0]  B_R = 9'h100, B_HI = 9'h080, B_LO = 9'h040, B_ZH = 9'h020, B_ZL = 9'h010;
    localparam logic [8:0]  B_PC = 9'h008, B_MDR = 9'h004, B_INP = 9'h002, B_C = 9'h001;
    localparam logic [10:0] I_R = 11'h400, I_HI = 11'h200, I_LO = 11'h100, I_Z = 11'h080, I_Y = 11'h040;
    localparam logic [10:0] I_PC = 11'h020, I_IR = 11'h010, I_MAR = 11'h008, I_MDR = 11'h004;
    localparam logic [10:0] I_CON = 11'h002, I_OUTP = 11'h001;
    localparam logic [2:0]  G_A = 3'b100, G_B = 3'b010, G_C = 3'b001, G_0 = 3'b000;
    localparam logic [4:0]  ADD = 5'b00011;

    typedef struct {
        string       tag;
        logic [34:0] vec;
    } exp_t;

    exp_t sb_q[$];
    event mid_ev;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [34:0] ev(input logic [8:0] bo, input logic [10:0] bi, input logic [2:0] g,
                                       input logic ba, input logic inc, input logic [2:0] mdr,
                                       input logic ram, input logic [4:0] alu, input logic r);
        return {bo, bi, g, ba, inc, mdr, ram, alu, r};
    endfunction

    function automatic logic [34:0] ex(input logic [8:0] bo, input logic [10:0] bi, input logic [2:0] g);
        return ev(bo, bi, g, 1'b0, 1'b0, 3'b000, 1'b0, ADD, 1'b1);
    endfunction

    localparam logic [34:0] V_OFF  = {9'd0, 11'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00011, 1'b0};
    localparam logic [34:0] V_IDLE = {9'd0, 11'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00011, 1'b1};

    task automatic push(input string tag, input logic [34:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic c, input string tag, input logic [34:0] v);
        @(posedge clk);
        #2;
        stall  = s;
        con_ff = c;
        push(tag, v);
    endtask

    task automatic t0(input string t, input logic [4:0] op);
        @(posedge clk);
        #2;
        opcode = op;
        stall  = 1'b0;
        con_ff = 1'b0;
        push({t, "_t0"}, ev(B_PC, I_MAR | I_Z, G_0, 1'b0, 1'b1, 3'b000, 1'b0, ADD, 1'b1));
    endtask

    function automatic logic [34:0] v_t1();
        return ev(B_ZL, I_PC | I_MDR, G_0, 1'b0, 1'b0, 3'b010, 1'b0, ADD, 1'b1);
    endfunction

    task automatic fetch(input string t, input logic [4:0] op);
        t0(t, op);
        step(1'b0, 1'b0, {t, "_t1"}, v_t1());
        step(1'b0, 1'b0, {t, "_t2"}, ex(B_MDR, I_IR, G_0));
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin : monitor
        exp_t        e;
        logic [34:0] act;
        forever begin
            @(negedge clk or mid_ev);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {busout, busin, gr, ba_out, inc_pc, mdr_sel, ram_write, alu_op, run};
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", e.tag, act, e.vec);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held, then released.
        @(posedge clk); #2; push("rst_hold", V_OFF);
        @(posedge clk); #2; clr = 1'b1; push("rst_release", V_OFF);

        // R-type add
        fetch("add", 5'b00011);
        step(1'b0, 1'b0, "add_t3", ex(B_R, I_Y, G_B));
        step(1'b0, 1'b0, "add_t4", ex(B_R, I_Z, G_C));
        step(1'b0, 1'b0, "add_t5", ex(B_ZL, I_R, G_A));

        // R-type with non-ADD alu_op
        fetch("rt5", 5'b00101);
        step(1'b0, 1'b0, "rt5_t3", ex(B_R, I_Y, G_B));
        step(1'b0, 1'b0, "rt5_t4", ev(B_R, I_Z, G_C, 1'b0, 1'b0, 3'b000, 1'b0, 5'b00101, 1'b1));
        step(1'b0, 1'b0, "rt5_t5", ex(B_ZL, I_R, G_A));

        // Immediate
        fetch("imm", 5'b01100);
        step(1'b0, 1'b0, "imm_t3", ex(B_R, I_Y, G_B));
        step(1'b0, 1'b0, "imm_t4", ev(B_C, I_Z, G_0, 1'b0, 1'b0, 3'b000, 1'b0, 5'b01100, 1'b1));
        step(1'b0, 1'b0, "imm_t5", ex(B_ZL, I_R, G_A));

        // ld
        fetch("ld", 5'b00000);
        step(1'b0, 1'b0, "ld_t3", ev(B_R, I_Y, G_B, 1'b1, 1'b0, 3'b000, 1'b0, ADD, 1'b1));
        step(1'b0, 1'b0, "ld_t4", ex(B_C, I_Z, G_0));
        step(1'b0, 1'b0, "ld_t5", ex(B_ZL, I_MAR, G_0));
        step(1'b0, 1'b0, "ld_t6", ev(9'd0, I_MDR, G_0, 1'b0, 1'b0, 3'b010, 1'b0, ADD, 1'b1));
        step(1'b0, 1'b0, "ld_t7", ex(B_MDR, I_R, G_A));

        // ldi
        fetch("ldi", 5'b00001);
        step(1'b0, 1'b0, "ldi_t3", ev(B_R, I_Y, G_B, 1'b1, 1'b0, 3'b000, 1'b0, ADD, 1'b1));
        step(1'b0, 1'b0, "ldi_t4", ex(B_C, I_Z, G_0));
        step(1'b0, 1'b0, "ldi_t5", ex(B_ZL, I_R, G_A));

        // Branch not taken, then taken
        for (int k = 0; k < 2; k++) begin
            fetch(k == 0 ? "brn" : "brt", 5'b10011);
            step(1'b0, 1'b0, "br_t3", ex(B_R, I_CON, G_A));
            step(1'b0, 1'b0, "br_t4", ex(B_PC, I_Y, G_0));
            step(1'b0, 1'b0, "br_t5", ex(B_C, I_Z, G_0));
            if (k == 0) step(1'b0, 1'b0, "br_t6_not_taken", V_IDLE);
            else        step(1'b0, 1'b1, "br_t6_taken", ex(B_ZL, I_PC, G_0));
        end

        // out with a 3-cycle stall during T1
        t0("out", 5'b10111);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "stall_t1", V_IDLE);
        step(1'b0, 1'b0, "stall_t1_reissue", v_t1());
        step(1'b0, 1'b0, "out_t2", ex(B_MDR, I_IR, G_0));
        step(1'b0, 1'b0, "out_t3", ex(B_R, I_OUTP, G_A));

        // in
        fetch("in", 5'b10110);
        step(1'b0, 1'b0, "in_t3", ex(B_INP, I_R, G_A));

        // nop: T2 goes straight to the next fetch
        fetch("nop", 5'b11111);

        // mul
        fetch("mul", 5'b01111);
        step(1'b0, 1'b0, "mul_t3", ex(B_R, I_Y, G_A));
        step(1'b0, 1'b0, "mul_t4", ev(B_R, I_Z, G_B, 1'b0, 1'b0, 3'b000, 1'b0, 5'b01111, 1'b1));
        step(1'b0, 1'b0, "mul_t5", ex(B_ZL, I_LO, G_0));
        step(1'b0, 1'b0, "mul_t6", ex(B_ZH, I_HI, G_0));

        // st, with clr pulsed mid-T7
        fetch("st", 5'b00010);
        step(1'b0, 1'b0, "st_t3", ev(B_R, I_Y, G_B, 1'b1, 1'b0, 3'b000, 1'b0, ADD, 1'b1));
        step(1'b0, 1'b0, "st_t4", ex(B_C, I_Z, G_0));
        step(1'b0, 1'b0, "st_t5", ex(B_ZL, I_MAR, G_0));
        step(1'b0, 1'b0, "st_t6", ev(B_R, I_MDR, G_A, 1'b0, 1'b0, 3'b001, 1'b0, ADD, 1'b1));
        step(1'b0, 1'b0, "st_t7", ev(9'd0, 11'd0, G_0, 1'b0, 1'b0, 3'b000, 1'b1, ADD, 1'b1));
        @(negedge clk); #2;
        clr = 1'b0;
        #1;
        push("st_t7_async_clr", V_OFF);
        -> mid_ev;
        @(posedge clk); #2; push("clr_hold", V_OFF);
        @(posedge clk); #2; clr = 1'b1; push("clr_release", V_OFF);

        // halt
        fetch("halt", 5'b11011);
        step(1'b0, 1'b0, "halt_t3", V_IDLE);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, "halt_hold", V_OFF);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
